// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, issue and write-back signals between the core pipeline and regfile_sb.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic rs1_busy;
    logic rs2_busy;
    logic issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic flush;
    logic [ADDR_W:0] pending_cnt;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
        input rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, pending_cnt
    );

    modport slave (
        input rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
        output rs1_rdata, rs2_rdata, rs1_busy, rs2_busy, pending_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register pending-write scoreboard and optional write-back bypass.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic clk,
    input logic rst_n,
    regfile_sb_if.slave bus
);
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;
    logic we;
    logic z1;
    logic z2;
    logic hit1;
    logic hit2;

    assign we = bus.wb_valid && !(ZERO_REG && bus.wb_rd == '0);
    assign z1 = ZERO_REG && bus.rs1_addr == '0;
    assign z2 = ZERO_REG && bus.rs2_addr == '0;
    // bypass is gated by reset so reads stay zero while rst_n is low
    assign hit1 = BYPASS && rst_n && bus.wb_valid && bus.wb_rd == bus.rs1_addr;
    assign hit2 = BYPASS && rst_n && bus.wb_valid && bus.wb_rd == bus.rs2_addr;

    assign bus.rs1_rdata = z1 ? '0 : hit1 ? bus.wb_data : regs[bus.rs1_addr];
    assign bus.rs2_rdata = z2 ? '0 : hit2 ? bus.wb_data : regs[bus.rs2_addr];
    assign bus.rs1_busy = !z1 && !hit1 && sb[bus.rs1_addr];
    assign bus.rs2_busy = !z2 && !hit2 && sb[bus.rs2_addr];

    // clear before set, so an issue to the write-back target leaves the new producer pending
    always_comb begin
        sb_next = sb;
        if (bus.wb_valid) sb_next[bus.wb_rd] = 1'b0;
        if (bus.issue_valid) sb_next[bus.issue_rd] = 1'b1;
        if (bus.flush) sb_next = '0;
        if (ZERO_REG) sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            sb <= '0;
            bus.pending_cnt <= '0;
        end else begin
            if (we) regs[bus.wb_rd] <= bus.wb_data;
            sb <= sb_next;
            bus.pending_cnt <= (ADDR_W + 1)'($countones(sb));
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table, hand sequences and random stimulus against a reference model
// for a bypassing, a non-bypassing and a 64-bit/16-entry register file.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) a ();
    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) b ();
    regfile_sb_if #(.XLEN(64), .ADDR_W(4)) c ();

    assign b.rs1_addr = a.rs1_addr;
    assign b.rs2_addr = a.rs2_addr;
    assign b.issue_valid = a.issue_valid;
    assign b.issue_rd = a.issue_rd;
    assign b.wb_valid = a.wb_valid;
    assign b.wb_rd = a.wb_rd;
    assign b.wb_data = a.wb_data;
    assign b.flush = a.flush;

    regfile_sb #(.XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) d0 (.clk(clk), .rst_n(rst_n), .bus(a));
    regfile_sb #(.XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b));
    regfile_sb #(.XLEN(64), .NREGS(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) d2 (.clk(clk), .rst_n(rst_n), .bus(c));

    // reference state: architectural values, pending-producer flags, and the lagging count
    logic [31:0] m_regs [32];
    bit m_busy [32];
    int m_cnt;

    typedef struct {
        logic iv; logic [4:0] ird; logic wv; logic [4:0] wrd; logic [31:0] wd; logic fl;
        logic [4:0] r1; logic [4:0] r2;
        logic [31:0] d1; logic b1; logic [31:0] d2; logic b2; logic [5:0] cnt;
    } vec_t;

    vec_t tab [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // one clock edge as the rules describe it: count pending first, then apply events
    task automatic m_edge();
        int live = 0;
        for (int i = 0; i < 32; i++) live += int'(m_busy[i]);
        m_cnt = live;
        if (a.wb_valid && a.wb_rd != 0) m_regs[a.wb_rd] = a.wb_data;
        if (a.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (a.issue_valid && a.wb_valid && a.issue_rd == a.wb_rd) begin
            m_busy[a.issue_rd] = (a.issue_rd != 0);
        end else begin
            if (a.wb_valid) m_busy[a.wb_rd] = 1'b0;
            if (a.issue_valid && a.issue_rd != 0) m_busy[a.issue_rd] = 1'b1;
        end
    endtask

    function automatic logic [31:0] e_data(input bit bp, input logic [4:0] ad);
        if (ad == 0) return '0;
        if (bp && a.wb_valid && a.wb_rd == ad) return a.wb_data;
        return m_regs[ad];
    endfunction

    function automatic logic e_busy(input bit bp, input logic [4:0] ad);
        if (ad == 0) return 1'b0;
        if (bp && a.wb_valid && a.wb_rd == ad) return 1'b0;
        return m_busy[ad];
    endfunction

    task automatic model_check();
        chk("byp_rs1_data", a.rs1_rdata, e_data(1, a.rs1_addr));
        chk("byp_rs2_data", a.rs2_rdata, e_data(1, a.rs2_addr));
        chk("byp_rs1_busy", a.rs1_busy, e_busy(1, a.rs1_addr));
        chk("byp_rs2_busy", a.rs2_busy, e_busy(1, a.rs2_addr));
        chk("byp_cnt", a.pending_cnt, m_cnt);
        chk("nbp_rs1_data", b.rs1_rdata, e_data(0, b.rs1_addr));
        chk("nbp_rs2_data", b.rs2_rdata, e_data(0, b.rs2_addr));
        chk("nbp_rs1_busy", b.rs1_busy, e_busy(0, b.rs1_addr));
        chk("nbp_rs2_busy", b.rs2_busy, e_busy(0, b.rs2_addr));
        chk("nbp_cnt", b.pending_cnt, m_cnt);
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic wv, input logic [4:0] wrd,
                         input logic [31:0] wd, input logic fl, input logic [4:0] r1, input logic [4:0] r2);
        a.issue_valid = iv;
        a.issue_rd = ird;
        a.wb_valid = wv;
        a.wb_rd = wrd;
        a.wb_data = wd;
        a.flush = fl;
        a.rs1_addr = r1;
        a.rs2_addr = r2;
    endtask

    function automatic logic [4:0] rnd_addr();
        return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        tab = '{
            '{1'b0, 5'd0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd3, 5'd0, 32'h12345678, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd3, 5'd0, 32'h12345678, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 32'h0, 1'b0, 32'h0, 1'b1, 6'd0},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 32'h0, 1'b0, 32'h0, 1'b1, 6'd1},
            '{1'b0, 5'd0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd4, 5'd4, 32'h55, 1'b0, 32'h55, 1'b0, 6'd1},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 32'h55, 1'b0, 32'h55, 1'b0, 6'd1},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 32'h55, 1'b0, 32'h55, 1'b0, 6'd0},
            '{1'b1, 5'd6, 1'b1, 5'd6, 32'h66, 1'b0, 5'd6, 5'd6, 32'h66, 1'b0, 32'h66, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd8, 32'h66, 1'b1, 32'h0, 1'b0, 6'd0},
            '{1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd8, 32'h66, 1'b1, 32'h0, 1'b0, 6'd1},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd8, 32'h66, 1'b0, 32'h0, 1'b0, 6'd1},
            '{1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd8, 32'h66, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0},
            '{1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd9, 5'd3, 32'hA5A5A5A5, 1'b0, 32'h12345678, 1'b0, 6'd0}
        };
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        c.issue_valid = 1'b0; c.issue_rd = '0; c.wb_valid = 1'b0; c.wb_rd = '0;
        c.wb_data = '0; c.flush = 1'b0; c.rs1_addr = '0; c.rs2_addr = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_cnt", a.pending_cnt, 6'd0);
        chk("reset_busy", a.rs1_busy, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tab[i].iv, tab[i].ird, tab[i].wv, tab[i].wrd, tab[i].wd, tab[i].fl, tab[i].r1, tab[i].r2);
            #1;
            chk($sformatf("tab%0d_rs1_data", i), a.rs1_rdata, tab[i].d1);
            chk($sformatf("tab%0d_rs1_busy", i), a.rs1_busy, tab[i].b1);
            chk($sformatf("tab%0d_rs2_data", i), a.rs2_rdata, tab[i].d2);
            chk($sformatf("tab%0d_rs2_busy", i), a.rs2_busy, tab[i].b2);
            chk($sformatf("tab%0d_cnt", i), a.pending_cnt, tab[i].cnt);
            model_check();
            @(posedge clk);
            m_edge();
        end

        // same-cycle write: bypassing file forwards, the other returns the stored value
        @(negedge clk);
        drive(0, 0, 1, 3, 32'hA5A5A5A5, 0, 3, 9);
        #1;
        chk("bypass_new", a.rs1_rdata, 32'hA5A5A5A5);
        chk("nobypass_old", b.rs1_rdata, 32'h12345678);
        chk("nobypass_x9", b.rs2_rdata, 32'hA5A5A5A5);
        @(posedge clk);
        m_edge();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                  $urandom, 1'($urandom_range(0, 15) == 0), rnd_addr(), rnd_addr());
            #1;
            model_check();
            @(posedge clk);
            m_edge();
        end

        // asynchronous reset between edges with live data and a pending write
        @(negedge clk);
        drive(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        @(posedge clk);
        m_edge();
        @(negedge clk);
        drive(1, 7, 0, 0, 0, 0, 5, 7);
        @(posedge clk);
        m_edge();
        repeat (2) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 5, 7);
            #1;
            model_check();
            @(posedge clk);
            m_edge();
        end
        #2;
        chk("pre_rst_x5", a.rs1_rdata, 32'hDEADBEEF);
        chk("pre_rst_x7_busy", a.rs2_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_x5", a.rs1_rdata, 32'h0);
        chk("rst_x7_busy", a.rs2_busy, 1'b0);
        chk("rst_cnt", a.pending_cnt, 6'd0);
        chk("rst_nbp_x5", b.rs1_rdata, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 64-bit, 16-entry file without a hardwired zero register
        @(negedge clk);
        c.wb_valid = 1'b1; c.wb_rd = 4'd0; c.wb_data = 64'h1_0000_0001; c.rs1_addr = 4'd0;
        #1;
        chk("w64_x0_bypass", c.rs1_rdata, 64'h1_0000_0001);
        @(negedge clk);
        c.wb_valid = 1'b0;
        #1;
        chk("w64_x0_stored", c.rs1_rdata, 64'h1_0000_0001);
        chk("w64_x0_idle", c.rs1_busy, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            c.issue_valid = 1'b1;
            c.issue_rd = 4'(i);
        end
        @(negedge clk);
        c.issue_valid = 1'b0;
        #1;
        chk("w64_x0_busy", c.rs1_busy, 1'b1);
        chk("w64_cnt15", c.pending_cnt, 5'd15);
        @(negedge clk);
        chk("w64_cnt16", c.pending_cnt, 5'd16);
        c.flush = 1'b1;
        @(negedge clk);
        c.flush = 1'b0;
        #1;
        chk("w64_flush_busy", c.rs1_busy, 1'b0);
        chk("w64_flush_cnt_lag", c.pending_cnt, 5'd16);
        @(negedge clk);
        chk("w64_flush_cnt", c.pending_cnt, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file with an integrated scoreboard: 2 combinational read ports, 1 synchronous write-back port, and per-register pending-write (busy) tracking.
- Sits between decode/issue and write-back of the pipelined core.
- Issue marks a destination busy. Write-back writes data and clears busy.
- Optional same-cycle write-to-read bypass. Flush drops all pending-write state.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, ≥2)
ADDR_W, 5, register address width; must equal log2(NREGS)
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy, never written

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_rdata  out  XLEN  read port 1 data (combinational)
rs2_rdata  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  register rs1_addr has an outstanding write (combinational)
rs2_busy  out  1  register rs2_addr has an outstanding write (combinational)
issue_valid  in  1  instruction issued that will write issue_rd
issue_rd  in  ADDR_W  destination of issued instruction
wb_valid  in  1  write-back this cycle
wb_rd  in  ADDR_W  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  clear all busy bits (pipeline squash)
pending_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): all NREGS data registers = 0, all busy bits = 0, pending_cnt = 0. Read outputs are combinational, so rdata = 0 and busy = 0 during reset.
- Write: at posedge, if wb_valid and not (ZERO_REG and wb_rd==0), regs[wb_rd] <= wb_data. Write latency is 1 cycle. Flush does not block the data write.
- Read: rsN_rdata = 0 if ZERO_REG and rsN_addr==0.
  - Else, if BYPASS and wb_valid and wb_rd==rsN_addr: rsN_rdata = wb_data.
  - Else: rsN_rdata = regs[rsN_addr].
- Busy bit update at posedge, in priority order:
  1. flush=1: all bits <= 0; issue_valid that cycle is ignored.
  2. issue_valid and issue_rd==wb_rd with wb_valid: bit stays/sets 1, because the new producer wins.
  3. Otherwise, issue_valid sets sb[issue_rd] and wb_valid clears sb[wb_rd], independently.
  - With ZERO_REG, index 0 is never set.
  - Issue to an already-busy register (WAW) is legal; the bit stays 1 and no count of producers is kept.
  - Write-back to a non-busy register is legal; data is written and the bit stays 0.
- Busy read: rsN_busy = sb[rsN_addr], forced 0 if ZERO_REG and addr==0.
  - If BYPASS and wb_valid and wb_rd==rsN_addr, forced 0, since the data is available this cycle.
- pending_cnt: registered popcount of the busy vector. It updates the cycle after the busy bits change, i.e. it reflects the busy state after the previous edge.
- Both read ports are fully independent; identical addresses on both ports are legal.
- Address ≥ NREGS cannot occur (ADDR_W = log2(NREGS)).

Test Plan:
- Reset mid-operation: write x5=0xDEADBEEF, issue x7, then assert rst_n=0 between clock edges → rs1_rdata(x5)=0, rs2_busy(x7)=0 and pending_cnt=0 immediately, without waiting for a clock edge.
- Write/read and zero register: wb x3=0x12345678, then read x3 → 0x12345678. wb x0=0xFFFFFFFF, then read x0 → 0.
- Bypass: BYPASS=1, wb_valid with x9=0xA5A5A5A5 while rs1_addr=9 → rs1_rdata=0xA5A5A5A5 and rs1_busy=0 in the same cycle. With BYPASS=0, the same stimulus returns the old value.
- Scoreboard: issue x4, next cycle rs2_busy(x4)=1 and pending_cnt updates to 1 one cycle later. wb x4=0x55 → busy clears after the edge and pending_cnt returns to 0.
- Simultaneous events:
  - Issue x6 and wb x6 in the same cycle → x6 busy=1 afterwards and data written.
  - Issue x6 alone → busy=1; then issue x8 with flush=1 → both bits 0 and pending_cnt goes to 0.
  - Issue x0 → never busy.
- Parametrisation: XLEN=64, NREGS=16, ADDR_W=4, ZERO_REG=0 → x0 writable (wb x0=0x1_0000_0001, read back exact value). Issue all 16 registers → pending_cnt=16.
